// File: rtl/mult_div_pkg.sv
// Shared constants for the sequential multiply/divide engine.
// FSM state encoding, default operand width and opcode values.
package mult_div_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_MULT  = 3'd1;
  localparam logic [2:0] S_DIV   = 3'd2;
  localparam logic [2:0] S_DZERO = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/mult_div_seq_if.sv
// Start/operand/result bundle between the control FSM and the engine.
// master: start_mult, start_div, op_a, op_b out; busy, done, div_zero, hi, lo in.
interface mult_div_seq_if
  import mult_div_pkg::*;
#(
  parameter int W = WIDTH_DEF
);

  logic         start_mult;
  logic         start_div;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  modport master (
    output start_mult, start_div, op_a, op_b,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start_mult, start_div, op_a, op_b,
    output busy, done, div_zero, hi, lo
  );

endinterface

// File: rtl/mult_div_seq_sign_fix.sv
// Sign handling around the magnitude-only divider.
// in: a, b, q_mag, r_mag, neg_q, neg_r; out: a_mag, b_mag, q, r.
module sign_fix
  import mult_div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] q_mag,
  input  logic [WIDTH-1:0] r_mag,
  input  logic             neg_q,
  input  logic             neg_r,
  output logic [WIDTH-1:0] a_mag,
  output logic [WIDTH-1:0] b_mag,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
);

  // -2^(W-1) maps to itself, which reads correctly as unsigned.
  assign a_mag = a[WIDTH-1] ? -a : a;
  assign b_mag = b[WIDTH-1] ? -b : b;

  assign q = neg_q ? -q_mag : q_mag;
  assign r = neg_r ? -r_mag : r_mag;

endmodule

// File: rtl/mult_div_seq.sv
// Sequential signed multiply (radix-2 Booth) / divide (restoring).
// clk, reset (sync, active-high); bus: slave side of mult_div_seq_if.
module mult_div_seq
  import mult_div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input logic clk,
  input logic reset,
  mult_div_seq_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int PW = 2 * WIDTH + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [2:0]       state;
  logic             op;
  logic [CW-1:0]    cnt;
  logic [PW-1:0]    pr;
  logic [WIDTH-1:0] m;
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             dz;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] q_out;
  logic [WIDTH-1:0] r_out;

  logic [WIDTH:0]   add_a;
  logic [WIDTH:0]   add_b;
  logic [WIDTH:0]   sum;
  logic             sub;
  logic [1:0]       pair;
  logic [PW-1:0]    step;

  // Mult layout: {A[W], Q[W], q-1}. Div layout: {R[W+1], Q[W]}.
  assign pair = pr[1:0];
  assign sum  = sub ? add_a - add_b : add_a + add_b;

  always_comb begin
    add_a = '0;
    add_b = '0;
    sub   = 1'b0;
    step  = pr;
    if (op == OP_MULT) begin
      // A is sign-extended by one bit so A-M never overflows.
      add_a = {pr[PW-1], pr[PW-1:WIDTH+1]};
      add_b = {m[WIDTH-1], m};
      sub   = (pair == 2'b10);
      if (pair[1] ^ pair[0]) begin
        step = {sum, pr[WIDTH:1]};
      end else begin
        step = {pr[PW-1], pr[PW-1:1]};
      end
    end else begin
      // Shifted remainder minus divisor; negative means restore.
      add_a = pr[PW-2:WIDTH-1];
      add_b = {1'b0, m};
      sub   = 1'b1;
      if (sum[WIDTH]) begin
        step = {pr[PW-2:0], 1'b0};
      end else begin
        step = {sum, pr[WIDTH-2:0], 1'b1};
      end
    end
  end

  sign_fix #(
    .WIDTH (WIDTH)
  ) u_fix (
    .a     (bus.op_a),
    .b     (bus.op_b),
    .q_mag (step[WIDTH-1:0]),
    .r_mag (step[2*WIDTH-1:WIDTH]),
    .neg_q (neg_q),
    .neg_r (neg_r),
    .a_mag (a_mag),
    .b_mag (b_mag),
    .q     (q_out),
    .r     (r_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      op    <= OP_MULT;
      cnt   <= '0;
      pr    <= '0;
      m     <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      dz    <= 1'b0;
    end else begin
      unique case (1'b1)
        state == S_IDLE: begin
          if (bus.start_mult) begin
            state <= S_MULT;
            op    <= OP_MULT;
            cnt   <= '0;
            dz    <= 1'b0;
            m     <= bus.op_a;
            pr    <= {{WIDTH{1'b0}}, bus.op_b, 1'b0};
          end else if (bus.start_div) begin
            op  <= OP_DIV;
            cnt <= '0;
            dz  <= 1'b0;
            if (bus.op_b == '0) begin
              state <= S_DZERO;
            end else begin
              state <= S_DIV;
              m     <= b_mag;
              pr    <= {{(WIDTH+1){1'b0}}, a_mag};
              neg_q <= bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1];
              neg_r <= bus.op_a[WIDTH-1];
            end
          end
        end
        state == S_MULT, state == S_DIV: begin
          pr  <= step;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= S_FIN;
            if (op == OP_MULT) begin
              hi <= step[PW-1:WIDTH+1];
              lo <= step[WIDTH:1];
            end else begin
              hi <= r_out;
              lo <= q_out;
            end
          end
        end
        state == S_DZERO: begin
          dz    <= 1'b1;
          state <= S_FIN;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = (state != S_IDLE);
  assign bus.done     = (state == S_FIN);
  assign bus.div_zero = dz;
  assign bus.hi       = hi;
  assign bus.lo       = lo;

endmodule
